// File: rtl/arbiter4.sv
// arbiter4: four-way round-robin arbiter with a per-grant time quantum.
//
// Shares one mux4 channel among requesters A..D (indices 0..3). It produces a
// registered one-hot grant and the matching 2-bit mux4 control code.
//
// Ports:
//   clk    - single clock; all state updates on the rising edge
//   reset  - synchronous, active-high reset
//   req    - request vector; bit i high while requester i wants the channel
//   grant  - registered one-hot grant, all-zero when idle
//   sel    - registered mux4 control, index of the granted requester;
//            holds its last value while idle so the mux output stays stable
//   busy   - high while any grant bit is high
//
// Parameter:
//   QUANTUM - max consecutive cycles a holder keeps the grant while another
//             requester waits (1..255)

module arbiter4 #(
    parameter int unsigned QUANTUM = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [7:0] CntMax = 8'(QUANTUM - 1);

    state_e     state_q;
    logic [1:0] owner_q;
    logic [1:0] ptr_q;
    logic [7:0] cnt_q;

    // {found, index} results of the two round-robin searches
    logic [2:0] idle_pick;
    logic [2:0] other_pick;

    // First set bit of r in the order s, s+1, s+2, s+3 (mod 4).
    // Scanning from the far end lets the nearest hit overwrite later ones.
    function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] s);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = s + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        idle_pick  = rr_search(req, ptr_q);
        // Exclude the current owner; search starts just past it.
        other_pick = rr_search(req & ~(4'b0001 << owner_q), owner_q + 2'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            grant   <= 4'b0000;
            sel     <= 2'd0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (idle_pick[2]) begin
                        state_q <= StGrant;
                        owner_q <= idle_pick[1:0];
                        cnt_q   <= 8'd0;
                        grant   <= 4'b0001 << idle_pick[1:0];
                        sel     <= idle_pick[1:0];
                        busy    <= 1'b1;
                    end
                end
                StGrant: begin
                    if (!req[owner_q]) begin
                        // Release: hand off without a bubble, or go idle.
                        ptr_q <= owner_q + 2'd1;
                        cnt_q <= 8'd0;
                        if (other_pick[2]) begin
                            owner_q <= other_pick[1:0];
                            grant   <= 4'b0001 << other_pick[1:0];
                            sel     <= other_pick[1:0];
                        end else begin
                            state_q <= StIdle;
                            grant   <= 4'b0000;
                            busy    <= 1'b0;
                        end
                    end else if (cnt_q == CntMax) begin
                        // Quantum spent: preempt if anyone else waits,
                        // otherwise the owner simply starts a new quantum.
                        cnt_q <= 8'd0;
                        if (other_pick[2]) begin
                            ptr_q   <= owner_q + 2'd1;
                            owner_q <= other_pick[1:0];
                            grant   <= 4'b0001 << other_pick[1:0];
                            sel     <= other_pick[1:0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant   <= 4'b0000;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter4.sv
// Scoreboard bench for arbiter4 (QUANTUM=4). Stimulus drives req/reset on
// the falling edge and queues the hand-computed outputs expected after the
// following rising edge; a separate monitor pops and compares.

module tb_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    arbiter4 #(.QUANTUM(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .grant(grant),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] g, input logic [1:0] s, input logic b);
        exp_t e;
        @(negedge clk);
        reset = r;
        req   = rq;
        e.tag = tag;
        e.g   = g;
        e.s   = s;
        e.b   = b;
        expq.push_back(e);
    endtask

    // Expect requester idx to hold the grant after this edge.
    task automatic step_own(input string tag, input logic [3:0] rq, input int idx);
        logic [3:0] g;
        g = 4'b0001 << idx;
        step(tag, 1'b0, rq, g, 2'(idx), 1'b1);
    endtask

    // Monitor: every edge the DUT presents registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (grant !== e.g || sel !== e.s || busy !== e.b) begin
                    errors++;
                    $display("FAIL %s: got grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
                             e.tag, grant, sel, busy, e.g, e.s, e.b);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0000;

        // Reset holds everything clear even with all requests pending.
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);

        // Release reset: ptr=0 picks requester 0, then rotate 4 cycles each.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) step_own("rotate", 4'b1111, k);
        end
        step_own("rotate_wrap", 4'b1111, 0);

        // Single requester: owner 0 releases, handoff to 2, held through expiry.
        for (int i = 0; i < 10; i++) step_own("single", 4'b0100, 2);
        step("single_drop", 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
        step("idle_hold", 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // ptr=3 after idle: 3 wins, then release wraps to 0 with no bubble.
        step_own("owner3", 4'b1001, 3);
        step_own("wrap_handoff", 4'b0001, 0);

        // Owner 1 releases to idle (ptr=2); 2,3,0,1 search picks 0.
        step_own("to_owner1", 4'b0010, 1);
        step("owner1_release", 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);
        step_own("ptr_fair", 4'b0011, 0);

        // Owner 2 reaches cnt=2, then reset pulse; ptr=0 then picks 1.
        for (int i = 0; i < 3; i++) step_own("to_owner2", 4'b0100, 2);
        step("reset_mid", 1'b1, 4'b0110, 4'b0000, 2'd0, 1'b0);
        step_own("post_reset", 4'b0110, 1);

        // Two-way contention: 1 holds 4 total, then 2 for 4, then back to 1.
        for (int i = 0; i < 3; i++) step_own("preempt1", 4'b0110, 1);
        for (int i = 0; i < 4; i++) step_own("preempt2", 4'b0110, 2);
        step_own("preempt_back", 4'b0110, 1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", expq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
